// File: rtl/snake_body_writer_pkg.sv
// Shared encodings for the snake body writer: directions, PS/2 scancodes, FSM states.
package snake_body_writer_pkg;

    // Opposite directions differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HEAD  = 2'd2,
        ST_DEAD  = 2'd3
    } state_e;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h1D;
    localparam logic [7:0] SC_DOWN  = 8'h1B;
    localparam logic [7:0] SC_LEFT  = 8'h1C;
    localparam logic [7:0] SC_RIGHT = 8'h23;

    // Tile coordinates are held in 8 bits internally (boards up to 256x256).
    localparam int COORD_W = 8;

    function automatic dir_e reverse_dir(input dir_e d);
        return dir_e'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/snake_body_writer_ps2_dir_decoder.sv
// PS/2 scancode to direction-request decoder with break-code suppression.
module ps2_dir_decoder
    import snake_body_writer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data_i,
    input  logic       read_data_i,
    input  logic [1:0] dir_i,
    output logic [1:0] next_dir_o
);

    logic break_pending_q, break_pending_d;
    dir_e next_dir_q, next_dir_d;
    dir_e req_dir;
    logic req_valid;

    // Map a make code onto the direction it requests.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        req_valid = 1'b1;
        req_dir   = DIR_RIGHT;
        case (rx_data_i)
            SC_UP:    req_dir = DIR_UP;
            SC_DOWN:  req_dir = DIR_DOWN;
            SC_LEFT:  req_dir = DIR_LEFT;
            SC_RIGHT: req_dir = DIR_RIGHT;
            default:  req_valid = 1'b0;
        endcase
    end

    // Swallow the byte after a break prefix; otherwise latch non-reversing requests.
    always_comb begin
        break_pending_d = break_pending_q;
        next_dir_d      = next_dir_q;
        if (read_data_i) begin
            if (break_pending_q) begin
                break_pending_d = 1'b0;
            end else if (rx_data_i == SC_BREAK) begin
                break_pending_d = 1'b1;
            end else if (req_valid && (req_dir != reverse_dir(dir_e'(dir_i)))) begin
                next_dir_d = req_dir;
            end
        end
    end

    // Decoder state registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            break_pending_q <= 1'b0;
            next_dir_q      <= DIR_RIGHT;
        end else begin
            break_pending_q <= break_pending_d;
            next_dir_q      <= next_dir_d;
        end
    end

    assign next_dir_o = next_dir_q;

endmodule

// File: rtl/snake_body_writer.sv
// Snake body register file: shifts the body and places a new head on each move tick.
module snake_body_writer
    import snake_body_writer_pkg::*;
#(
    parameter int MAX_SEG = 100,
    parameter int GRID_W  = 8,
    parameter int GRID_H  = 8,
    parameter int START_X = 3,
    parameter int START_Y = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   read_data,
    input  logic                   tick,
    input  logic                   grow,
    output logic [32*MAX_SEG-1:0]  x_values,
    output logic [32*MAX_SEG-1:0]  y_values,
    output logic [6:0]             length,
    output logic                   busy,
    output logic                   collision
);

    localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(GRID_H - 1);
    localparam logic [COORD_W-1:0] X_START = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] Y_START = COORD_W'(START_Y);
    localparam logic [6:0]         MAX_LEN = 7'(MAX_SEG);

    state_e state_q, state_d;
    dir_e   dir_q, dir_d;
    logic [1:0] next_dir;
    logic [6:0] length_q, length_d;
    logic grow_pending_q, grow_pending_d;
    logic collision_q, collision_d;
    logic [COORD_W-1:0] seg_x_q [MAX_SEG];
    logic [COORD_W-1:0] seg_y_q [MAX_SEG];
    logic [COORD_W-1:0] seg_x_d [MAX_SEG];
    logic [COORD_W-1:0] seg_y_d [MAX_SEG];
    logic [COORD_W-1:0] head_x, head_y;
    logic hit;

    ps2_dir_decoder u_dir_decoder (
        .clk         (clk),
        .reset       (reset),
        .rx_data_i   (rx_data),
        .read_data_i (read_data),
        .dir_i       (dir_q),
        .next_dir_o  (next_dir)
    );

    // Candidate head: current head stepped one tile in the committed direction, wrapping at edges.
    always_comb begin
        head_x = seg_x_q[0];
        head_y = seg_y_q[0];
        case (dir_q)
            DIR_UP:    head_y = (seg_y_q[0] == '0)     ? Y_LAST : seg_y_q[0] - 1'b1;
            DIR_DOWN:  head_y = (seg_y_q[0] == Y_LAST) ? '0     : seg_y_q[0] + 1'b1;
            DIR_LEFT:  head_x = (seg_x_q[0] == '0)     ? X_LAST : seg_x_q[0] - 1'b1;
            DIR_RIGHT: head_x = (seg_x_q[0] == X_LAST) ? '0     : seg_x_q[0] + 1'b1;
            default:   head_x = seg_x_q[0];
        endcase
    end

    // Candidate head against the live post-shift body; the vacated tail sits at index length and is excluded.
    always_comb begin
        hit = 1'b0;
        for (int i = 1; i < MAX_SEG; i++) begin
            if ((i < int'(length_q)) && (seg_x_q[i] == head_x) && (seg_y_q[i] == head_y)) begin
                hit = 1'b1;
            end
        end
    end

    // Move sequencer next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (tick) state_d = ST_SHIFT;
            ST_SHIFT: state_d = ST_HEAD;
            ST_HEAD:  state_d = hit ? ST_DEAD : ST_IDLE;
            ST_DEAD:  state_d = ST_DEAD;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Body datapath: shift in SHIFT, write head / trim / detect collision in HEAD.
    always_comb begin
        seg_x_d        = seg_x_q;
        seg_y_d        = seg_y_q;
        dir_d          = dir_q;
        length_d       = length_q;
        grow_pending_d = grow_pending_q | grow;
        collision_d    = collision_q;
        case (state_q)
            ST_SHIFT: begin
                for (int i = 1; i < MAX_SEG; i++) begin
                    seg_x_d[i] = seg_x_q[i-1];
                    seg_y_d[i] = seg_y_q[i-1];
                end
                dir_d = dir_e'(next_dir);
                if (grow_pending_q) begin
                    if (length_q < MAX_LEN) length_d = length_q + 7'd1;
                    // A grow arriving during SHIFT belongs to the following move.
                    grow_pending_d = grow;
                end
            end
            ST_HEAD: begin
                seg_x_d[0] = head_x;
                seg_y_d[0] = head_y;
                for (int i = 1; i < MAX_SEG; i++) begin
                    if (i >= int'(length_q)) begin
                        seg_x_d[i] = '0;
                        seg_y_d[i] = '0;
                    end
                end
                if (hit) collision_d = 1'b1;
            end
            default: ;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Body and control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the segment array is reset explicitly because the head start tile and zeroed tail are visible outputs.
            for (int i = 0; i < MAX_SEG; i++) begin
                seg_x_q[i] <= (i == 0) ? X_START : '0;
                seg_y_q[i] <= (i == 0) ? Y_START : '0;
            end
            dir_q          <= DIR_RIGHT;
            length_q       <= 7'd1;
            grow_pending_q <= 1'b0;
            collision_q    <= 1'b0;
        end else begin
            seg_x_q        <= seg_x_d;
            seg_y_q        <= seg_y_d;
            dir_q          <= dir_d;
            length_q       <= length_d;
            grow_pending_q <= grow_pending_d;
            collision_q    <= collision_d;
        end
    end

    // Zero-extend each segment coordinate onto its 32-bit output lane.
    always_comb begin
        x_values = '0;
        y_values = '0;
        for (int i = 0; i < MAX_SEG; i++) begin
            x_values[32*i +: 32] = 32'(seg_x_q[i]);
            y_values[32*i +: 32] = 32'(seg_y_q[i]);
        end
    end

    assign length    = length_q;
    assign busy      = (state_q == ST_SHIFT) || (state_q == ST_HEAD);
    assign collision = collision_q;

endmodule

// File: tb/tb_snake_body_writer.sv
// Self-checking bench for snake_body_writer against a queue-based snake model.
module tb_snake_body_writer;
    import snake_body_writer_pkg::*;

    // A taller board gives room for a 100-segment snake without self-collision.
    localparam int MAX_SEG = 100;
    localparam int GW      = 8;
    localparam int GH      = 16;
    localparam int SX      = 3;
    localparam int SY      = 3;

    logic clk = 1'b0;
    logic reset, read_data, tick, grow;
    logic [7:0] rx_data;
    logic [32*MAX_SEG-1:0] x_values, y_values;
    logic [6:0] length;
    logic busy, collision;

    snake_body_writer #(
        .MAX_SEG (MAX_SEG), .GRID_W (GW), .GRID_H (GH), .START_X (SX), .START_Y (SY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .read_data (read_data),
        .tick      (tick),
        .grow      (grow),
        .x_values  (x_values),
        .y_values  (y_values),
        .length    (length),
        .busy      (busy),
        .collision (collision)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: body as a queue of tiles, head at index 0.
    int bx[$];
    int by[$];
    int m_dir, m_next, m_break, m_growp, m_coll, m_dead;
    logic [7:0] byte_tbl [8] = '{8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h00, 8'h5A, 8'hE0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [32*MAX_SEG-1:0] obs,
                           input logic [32*MAX_SEG-1:0] exp);
        int k;
        n_assert++;
        assert (obs === exp) else begin
            k = 0;
            while (k < MAX_SEG - 1 && obs[32*k +: 32] === exp[32*k +: 32]) k++;
            n_fail++;
            $error("FAIL %s: seg %0d observed %0d expected %0d", tag, k, obs[32*k +: 32], exp[32*k +: 32]);
        end
    endtask

    task automatic model_reset();
        bx.delete();
        by.delete();
        bx.push_back(SX);
        by.push_back(SY);
        m_dir = 3; m_next = 3; m_break = 0; m_growp = 0; m_coll = 0; m_dead = 0;
    endtask

    function automatic int opposite(input int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int req;
        if (m_break != 0) begin
            m_break = 0;
            return;
        end
        if (b == 8'hF0) begin
            m_break = 1;
            return;
        end
        case (b)
            8'h1D: req = 0;
            8'h1B: req = 1;
            8'h1C: req = 2;
            8'h23: req = 3;
            default: req = -1;
        endcase
        if (req >= 0 && req != opposite(m_dir)) m_next = req;
    endtask

    task automatic model_move();
        int dx, dy, nx, ny, len, lim;
        bit g;
        if (m_dead != 0) return;
        m_dir = m_next;
        len = bx.size();
        g = (m_growp != 0) && (len < MAX_SEG);
        m_growp = 0;
        dx = 0; dy = 0;
        case (m_dir)
            0: dy = -1;
            1: dy = 1;
            2: dx = -1;
            default: dx = 1;
        endcase
        nx = (bx[0] + dx + GW) % GW;
        ny = (by[0] + dy + GH) % GH;
        // Without growth the old tail leaves this move, so it cannot be hit.
        lim = g ? len : len - 1;
        for (int k = 0; k < lim; k++) begin
            if (bx[k] == nx && by[k] == ny) m_coll = 1;
        end
        bx.push_front(nx);
        by.push_front(ny);
        if (!g) begin
            void'(bx.pop_back());
            void'(by.pop_back());
        end
        if (m_coll != 0) m_dead = 1;
    endtask

    task automatic check_all(input string tag);
        logic [32*MAX_SEG-1:0] ex, ey;
        ex = '0;
        ey = '0;
        for (int i = 0; i < bx.size(); i++) begin
            ex[32*i +: 32] = 32'(bx[i]);
            ey[32*i +: 32] = 32'(by[i]);
        end
        chk({tag, "_len"}, 32'(length), 32'(bx.size()));
        chk({tag, "_coll"}, 32'(collision), 32'(m_coll));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk_bus({tag, "_x"}, x_values, ex);
        chk_bus({tag, "_y"}, y_values, ey);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        read_data = 1'b1;
        step();
        read_data = 1'b0;
        model_byte(b);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
    endtask

    // One tick-driven move; optionally a scancode arrives during SHIFT.
    task automatic move(input string tag, input bit g, input bit hb = 1'b0, input logic [7:0] b = 8'h00);
        tick = 1'b1;
        grow = g;
        if (g) m_growp = 1;
        step();
        tick = 1'b0;
        grow = 1'b0;
        if (m_dead != 0) begin
            chk({tag, "_dead_busy0"}, 32'(busy), 32'd0);
            if (hb) send_byte(b); else step();
            step();
        end else begin
            chk({tag, "_busy_shift"}, 32'(busy), 32'd1);
            if (hb) begin
                rx_data = b;
                read_data = 1'b1;
            end
            step();
            read_data = 1'b0;
            chk({tag, "_busy_head"}, 32'(busy), 32'd1);
            step();
            model_move();
            if (hb) model_byte(b);
        end
        check_all(tag);
    endtask

    // Boustrophedon steering so a long snake never meets itself.
    task automatic steer();
        if (m_dir == 3 && bx[0] == GW - 1)      send_byte(SC_DOWN);
        else if (m_dir == 2 && bx[0] == 0)      send_byte(SC_DOWN);
        else if (m_dir == 1)                    send_byte((bx[0] == GW - 1) ? SC_LEFT : SC_RIGHT);
    endtask

    initial begin
        reset = 1'b1; read_data = 1'b0; tick = 1'b0; grow = 1'b0; rx_data = 8'h00;
        step();
        step();
        reset = 1'b0;
        model_reset();
        check_all("reset");
        chk("reset_head_x", x_values[31:0], 32'd3);

        // First move: head (4,3), length 1.
        move("mv1", 1'b0);
        chk("mv1_head_x", x_values[31:0], 32'd4);

        // Walk right to the last column, then wrap to x=0.
        for (int i = 0; i < 3; i++) move("walk", 1'b0);
        move("xwrap", 1'b0);
        chk("xwrap_head_x", x_values[31:0], 32'd0);

        // Up from y=0 wraps to the bottom row.
        do_reset();
        send_byte(SC_UP);
        for (int i = 0; i < 3; i++) move("up", 1'b0);
        move("ywrap", 1'b0);
        chk("ywrap_head_y", y_values[31:0], 32'(GH - 1));

        // Reverse request dropped; break-prefixed make code ignored.
        do_reset();
        send_byte(SC_LEFT);
        move("rev", 1'b0);
        chk("rev_head_x", x_values[31:0], 32'd4);
        send_byte(SC_BREAK);
        send_byte(SC_UP);
        move("brk", 1'b0);
        chk("brk_head_y", y_values[31:0], 32'd3);

        // Scancode during SHIFT steers only the following move.
        move("shift_byte", 1'b0, 1'b1, SC_UP);
        chk("shift_byte_y", y_values[31:0], 32'd3);
        move("after_shift_byte", 1'b0);
        chk("after_shift_byte_y", y_values[31:0], 32'd2);

        // Reset overrides tick, grow and read_data in the same cycle.
        reset = 1'b1; tick = 1'b1; grow = 1'b1; read_data = 1'b1; rx_data = SC_UP;
        step();
        reset = 1'b0; tick = 1'b0; grow = 1'b0; read_data = 1'b0;
        model_reset();
        check_all("rst_override");
        move("rst_override_mv", 1'b0);

        // Growth from reset up to saturation.
        do_reset();
        move("grow1", 1'b1);
        chk("grow1_seg1_x", x_values[63:32], 32'd3);
        chk("grow1_seg1_y", y_values[63:32], 32'd3);
        for (int k = 0; k < 150 && bx.size() < MAX_SEG; k++) begin
            steer();
            move("grow_loop", 1'b1);
        end
        chk("grow_full_len", 32'(length), 32'd100);
        steer();
        move("grow_sat", 1'b1);
        chk("grow_sat_len", 32'(length), 32'd100);
        steer();
        move("grow_sat2", 1'b0);

        // Length-5 body looped so the head lands on segment 3.
        do_reset();
        for (int i = 0; i < 4; i++) move("c_grow", 1'b1);
        send_byte(SC_DOWN);
        move("c_down", 1'b0);
        send_byte(SC_LEFT);
        move("c_left", 1'b0);
        send_byte(SC_UP);
        move("c_hit", 1'b0);
        chk("c_hit_flag", 32'(collision), 32'd1);
        chk("c_hit_state", 32'(dut.state_q), 32'(ST_DEAD));
        move("c_dead1", 1'b0);
        move("c_dead2", 1'b1);

        // Head moving into the tile the tail vacates is legal.
        do_reset();
        for (int i = 0; i < 3; i++) move("t_grow", 1'b1);
        send_byte(SC_DOWN);
        move("t_down", 1'b0);
        send_byte(SC_LEFT);
        move("t_left", 1'b0);
        send_byte(SC_UP);
        move("t_tail", 1'b0);
        chk("t_tail_noflag", 32'(collision), 32'd0);

        // Reset while in HEAD.
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        chk("rst_head_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        check_all("rst_in_head");

        // Randomized moves, scancodes and grows against the model.
        for (int it = 0; it < 80; it++) begin
            int nb;
            nb = int'($urandom_range(0, 2));
            for (int j = 0; j < nb; j++) send_byte(byte_tbl[$urandom_range(0, 7)]);
            move("rand", 1'($urandom_range(0, 1)));
            if (m_dead != 0 && $urandom_range(0, 3) == 0) begin
                do_reset();
                check_all("rand_reset");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
